// File: rtl/demux1_8_buf.sv
// Registered 1-to-8 demultiplexer: steers one producer word into one of eight
// single-entry slots, each drained independently through its own valid/ready pair.
module demux1_8_buf #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         in_sel,
  input  logic [WIDTH-1:0]   in_data,
  output logic [7:0]         out_valid,
  input  logic [7:0]         out_ready,
  output logic [8*WIDTH-1:0] out_data,
  output logic [3:0]         occupancy,
  output logic               err
);

  logic [7:0]       valid_q;
  logic [7:0]       valid_d;
  logic [WIDTH-1:0] data_q [8];
  logic [WIDTH-1:0] data_d [8];
  logic             accept;

  // A full slot that is being drained this cycle may be refilled in the same cycle.
  assign in_ready = ~valid_q[in_sel] | out_ready[in_sel];
  assign accept   = in_valid & in_ready;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_slot
      logic hit;
      assign hit = accept & (in_sel == 3'(gi));

      always_comb begin
        valid_d[gi] = hit | (valid_q[gi] & ~out_ready[gi]);
        data_d[gi]  = hit ? in_data : data_q[gi];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_q[gi] <= 1'b0;
          data_q[gi]  <= '0;
        end else begin
          valid_q[gi] <= valid_d[gi];
          data_q[gi]  <= data_d[gi];
        end
      end

      assign out_data[gi*WIDTH +: WIDTH] = data_q[gi];
    end
  endgenerate

  assign out_valid = valid_q;

  always_comb begin
    occupancy = 4'd0;
    for (int i = 0; i < 8; i++) begin
      occupancy = occupancy + 4'(valid_q[i]);
    end
  end

  // Flags an unknown select or data while the producer claims a valid word.
  assign err = in_valid & ((^{in_sel, in_data}) === 1'bx);

endmodule

// File: tb/tb_demux1_8_buf.sv
// Self-checking bench for demux1_8_buf: directed scenarios plus randomized traffic
// compared against a per-channel slot model.
module tb_demux1_8_buf;

  localparam int WIDTH = 16;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [2:0]         in_sel;
  logic [WIDTH-1:0]   in_data;
  logic [7:0]         out_valid;
  logic [7:0]         out_ready;
  logic [8*WIDTH-1:0] out_data;
  logic [3:0]         occupancy;
  logic               err;

  int checks;
  int failures;

  // Reference: each channel holds at most one pending word.
  bit          m_full [8];
  logic [15:0] m_word [8];

  demux1_8_buf #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 8; k++) begin
      m_full[k] = 1'b0;
      m_word[k] = 16'h0000;
    end
  endtask

  // Checks every observable output against the model at the current inputs.
  task automatic check_all(input string tag);
    logic [7:0]   ev;
    logic [127:0] ed;
    int           cnt;
    ev  = '0;
    ed  = '0;
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      ev[k] = m_full[k];
      ed[k*16 +: 16] = m_word[k];
      if (m_full[k]) cnt++;
    end
    chk({tag, ".out_valid"}, 128'(out_valid), 128'(ev));
    chk({tag, ".out_data"}, out_data, ed);
    chk({tag, ".occupancy"}, 128'(occupancy), 128'(cnt));
    chk({tag, ".in_ready"}, 128'(in_ready), 128'(!m_full[in_sel] || out_ready[in_sel]));
    chk({tag, ".err"}, 128'(err), 128'(in_valid && $isunknown({in_sel, in_data})));
    $display("txn %-10s v=%b sel=%0d d=%h rdy=%h -> out_valid=%h occ=%0d in_ready=%b",
             tag, in_valid, in_sel, in_data, out_ready, out_valid, occupancy, in_ready);
  endtask

  task automatic drive(input logic v, input logic [2:0] s, input logic [15:0] d,
                       input logic [7:0] r);
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = r;
  endtask

  // One clock edge: model drains first, then the accepted word takes its slot.
  task automatic cycle();
    bit take;
    @(posedge clk);
    take = in_valid && (!m_full[in_sel] || out_ready[in_sel]);
    for (int k = 0; k < 8; k++) begin
      if (out_ready[k]) m_full[k] = 1'b0;
    end
    if (take) begin
      m_full[in_sel] = 1'b1;
      m_word[in_sel] = in_data;
    end
    @(negedge clk);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    model_clear();
    rst_n = 1'b0;
    drive(1'b0, 3'd0, 16'h0000, 8'h00);
    @(negedge clk);
    @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;
    @(negedge clk);
    for (int s = 0; s < 8; s++) begin
      in_sel = 3'(s);
      #1;
      check_all("idle");
    end

    // Single word to channel 3
    drive(1'b1, 3'd3, 16'hBEEF, 8'h00);
    cycle();
    drive(1'b0, 3'd0, 16'h0000, 8'h00);
    #1;
    check_all("beef");
    chk("beef.slot3", 128'(out_data[63:48]), 128'(16'hBEEF));
    drive(1'b0, 3'd0, 16'h0000, 8'h08);
    cycle();
    check_all("drain3");

    // Fill all eight slots
    for (int s = 0; s < 8; s++) begin
      drive(1'b1, 3'(s), 16'(s), 8'h00);
      cycle();
    end
    drive(1'b1, 3'd5, 16'hDEAD, 8'h00);
    #1;
    check_all("full");
    chk("full.in_ready5", 128'(in_ready), 128'(0));
    for (int s = 0; s < 8; s++) begin
      in_sel = 3'(s);
      #1;
      check_all("fullsel");
    end
    in_sel = 3'd5;
    cycle();
    check_all("stall");
    chk("stall.slot5", 128'(out_data[95:80]), 128'(16'h0005));
    drive(1'b0, 3'd0, 16'h0000, 8'hFF);
    cycle();
    check_all("drainall");

    // Drain and refill slot 2 in one cycle
    drive(1'b1, 3'd2, 16'h1111, 8'h00);
    cycle();
    drive(1'b1, 3'd2, 16'h2222, 8'h04);
    #1;
    check_all("refill");
    chk("refill.in_ready", 128'(in_ready), 128'(1));
    cycle();
    drive(1'b0, 3'd0, 16'h0000, 8'h00);
    #1;
    check_all("refilled");
    chk("refilled.slot2", 128'(out_data[47:32]), 128'(16'h2222));
    drive(1'b0, 3'd0, 16'h0000, 8'h04);
    cycle();

    // Slots 0,4,7 drained together
    drive(1'b1, 3'd0, 16'hA000, 8'h00); cycle();
    drive(1'b1, 3'd4, 16'hA004, 8'h00); cycle();
    drive(1'b1, 3'd7, 16'hA007, 8'h00); cycle();
    drive(1'b0, 3'd0, 16'h0000, 8'h91);
    cycle();
    drive(1'b0, 3'd0, 16'h0000, 8'h00);
    #1;
    check_all("multi");
    chk("multi.out_valid", 128'(out_valid), 128'(8'h00));

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
            16'($urandom), 8'($urandom));
      #1;
      check_all("rand_in");
      cycle();
      check_all("rand_out");
    end

    // Asynchronous reset between edges discards a pending word
    drive(1'b1, 3'd6, 16'h6666, 8'h00);
    cycle();
    drive(1'b0, 3'd0, 16'h0000, 8'h00);
    #1;
    check_all("slot6");
    #1;
    rst_n = 1'b0;
    model_clear();
    #1;
    check_all("async_rst");
    chk("async_rst.occ", 128'(occupancy), 128'(0));
    in_valid = 1'b1;
    in_data  = 'x;
    #1;
    chk("err_x", 128'(err), 128'(in_valid && $isunknown({in_sel, in_data})));
    in_valid = 1'b0;
    #1;
    chk("err_idle", 128'(err), 128'(0));
    drive(1'b0, 3'd0, 16'h0000, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_all("release");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
